relu_tensor_serializer: RTL

RELU_TENSOR_SERIALIZER -- requirements
Module: relu_tensor_serializer

---
 rtl/relu_tensor_serializer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/relu_tensor_serializer.sv
// Captures an N-element tensor frame on load and streams it one element per cycle, first element 1 cycle after acceptance; out_ready low holds the presented element.
// `define RELU_SER_ZERO_SKIP_EN drops zero-valued elements from the stream without inserting bubbles.
module relu_tensor_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int BATCH_SIZE = 1,
  parameter int CHANNELS   = 1,
  parameter int HEIGHT     = 4,
  parameter int WIDTH      = 4,
  localparam int N         = BATCH_SIZE * CHANNELS * HEIGHT * WIDTH,
  localparam int IW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N*DATA_WIDTH-1:0] in_tensor,
  input  logic                    load_valid,
  output logic                    load_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [IW-1:0]           out_index,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    frame_done,
  output logic                    busy
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                  state_q, state_d;
  logic [N*DATA_WIDTH-1:0] frame_q, frame_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [IW-1:0]           out_index_q, out_index_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic                    frame_done_q, frame_done_d;

  logic                    load_fire;
  logic [N*DATA_WIDTH-1:0] src;
  logic [31:0]             start;
  logic                    found;
  logic                    more;
  logic [IW-1:0]           pick;
  logic [DATA_WIDTH-1:0]   sel_data;

  // The same search serves both the first element after a load (from in_tensor)
  // and every subsequent element (from the held frame, after the current index).
  always_comb begin
    load_fire = (state_q == IDLE) && load_valid;
    src       = load_fire ? in_tensor : frame_q;
    start     = load_fire ? 32'd0 : 32'(out_index_q) + 32'd1;
  end

`ifdef RELU_SER_ZERO_SKIP_EN
  logic [N-1:0] nz;

  always_comb begin
    nz = '0;
    for (int k = 0; k < N; k++) begin
      nz[k] = |src[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // First non-zero at or after start; 'more' says another non-zero follows it.
  always_comb begin
    found = 1'b0;
    more  = 1'b0;
    pick  = '0;
    for (int k = 0; k < N; k++) begin
      if (($unsigned(k) >= start) && nz[k]) begin
        if (!found) begin
          found = 1'b1;
          pick  = IW'(k);
        end else begin
          more = 1'b1;
        end
      end
    end
  end
`else
  always_comb begin
    found = 1'b1;
    pick  = IW'(start);
    more  = (start < 32'(N - 1));
  end
`endif

  always_comb begin
    sel_data = DATA_WIDTH'(src >> (32'(pick) * 32'(DATA_WIDTH)));
  end

  always_comb begin
    state_d      = state_q;
    frame_d      = frame_q;
    out_data_d   = out_data_q;
    out_index_d  = out_index_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          frame_d     = in_tensor;
          state_d     = STREAM;
          out_valid_d = found;
          out_data_d  = sel_data;
          out_index_d = pick;
          out_last_d  = found && !more;
        end
      end
      STREAM: begin
        if (!out_valid_q) begin
          // Frame had nothing to emit: close it one cycle after acceptance.
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end else if (out_ready) begin
          if (out_last_q) begin
            state_d      = IDLE;
            out_valid_d  = 1'b0;
            out_last_d   = 1'b0;
            frame_done_d = 1'b1;
          end else begin
            out_data_d  = sel_data;
            out_index_d = pick;
            out_last_d  = !more;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      frame_q      <= '0;
      out_data_q   <= '0;
      out_index_q  <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      out_data_q   <= out_data_d;
      out_index_q  <= out_index_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q == STREAM);
  assign out_data   = out_data_q;
  assign out_index  = out_index_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign frame_done = frame_done_q;

endmodule
